// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage behind the execute stage.
//
// Load and store requests are carried out one byte per cycle over a byte-wide
// RAM port, least significant byte first (little-endian). Load results are
// sign- or zero-extended. Non-memory requests pass their register write-back
// fields straight through. While a multi-cycle access is in flight, stall_req
// tells the upstream stage to hold the EX/MEM register.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid            EX/MEM request valid
//   in_modify_flag      write-back enable
//   in_modify_address   destination register index
//   in_modify_data      result for non-load ops
//   in_load, in_save    request is a load / store (load wins if both are set)
//   in_sl_address       byte address of the access
//   in_sl_data          store data
//   in_sl_length        access size code: bit 2 -> 4 bytes, bit 1 -> 2, else 1
//   in_sl_signed        sign-extend the load result
//   stall_req           upstream must hold the EX/MEM register
//   out_valid           single-cycle pulse: write-back fields are valid
//   modify_flag, modify_address, modify_data   write-back fields
//   mem_a, mem_dout, mem_wr                    RAM byte address, write byte, write strobe
//   mem_din             RAM read byte, one cycle after mem_a
module mem_access #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_modify_flag,
   input  logic [31:0]       in_modify_address,
   input  logic [31:0]       in_modify_data,
   input  logic              in_load,
   input  logic              in_save,
   input  logic [ADDR_W-1:0] in_sl_address,
   input  logic [31:0]       in_sl_data,
   input  logic [2:0]        in_sl_length,
   input  logic              in_sl_signed,
   output logic              stall_req,
   output logic              out_valid,
   output logic              modify_flag,
   output logic [31:0]       modify_address,
   output logic [31:0]       modify_data,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din
);

   typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

   state_e            state;
   logic [2:0]        idx;      // byte counter within the current access
   logic [2:0]        n_q;      // access length in bytes: 1, 2 or 4
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic              sgn_q;
   logic              mf_q;
   logic [31:0]       maddr_q;
   logic [31:0]       mdata_q;
   logic [31:0]       word_q;   // load bytes assembled so far

   logic              req_mem;
   logic [ADDR_W-1:0] addr_idx;
   logic [1:0]        byte_sel;
   logic [31:0]       load_word;
   logic [31:0]       load_ext;
   logic [7:0]        store_byte;

   // Size decode; illegal codes fall through the same priority rule.
   function automatic logic [2:0] len_to_n(input logic [2:0] len);
      if (len[2]) begin
         return 3'd4;
      end
      if (len[1]) begin
         return 3'd2;
      end
      return 3'd1;
   endfunction

   assign req_mem    = in_load | in_save;
   assign addr_idx   = addr_q + ADDR_W'(idx);
   assign store_byte = data_q[{idx[1:0], 3'b000} +: 8];

   // mem_din answers the address presented one cycle earlier, so in the cycle
   // with counter value idx it holds byte idx-1. Merging it here lets the final
   // byte go straight into the result without an extra cycle.
   always_comb begin
      load_word = word_q;
      byte_sel  = 2'(idx - 3'd1);
      if (idx != 3'd0) begin
         load_word[{byte_sel, 3'b000} +: 8] = mem_din;
      end
   end

   // Extension only applies to sub-word loads; full words ignore the signed flag.
   always_comb begin
      case (n_q)
         3'd1:    load_ext = {{24{sgn_q & load_word[7]}}, load_word[7:0]};
         3'd2:    load_ext = {{16{sgn_q & load_word[15]}}, load_word[15:0]};
         default: load_ext = load_word;
      endcase
   end

   // RAM strobes and stall request. Everything is forced low during reset so
   // an aborted store cannot write in the reset cycle.
   always_comb begin
      stall_req = 1'b0;
      mem_a     = '0;
      mem_dout  = 8'h00;
      mem_wr    = 1'b0;
      if (!rst) begin
         case (state)
            StIdle: begin
               stall_req = in_valid & req_mem;
            end
            StLoad: begin
               // The last load cycle only collects the trailing byte; stall
               // drops there so upstream advances as the FSM returns to idle.
               if (idx < n_q) begin
                  mem_a     = addr_idx;
                  stall_req = 1'b1;
               end
            end
            StStore: begin
               mem_a     = addr_idx;
               mem_dout  = store_byte;
               mem_wr    = 1'b1;
               stall_req = (idx != 3'(n_q - 3'd1));
            end
            default: begin
               stall_req = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= StIdle;
         idx            <= 3'd0;
         n_q            <= 3'd1;
         addr_q         <= '0;
         data_q         <= 32'h0;
         sgn_q          <= 1'b0;
         mf_q           <= 1'b0;
         maddr_q        <= 32'h0;
         mdata_q        <= 32'h0;
         word_q         <= 32'h0;
         out_valid      <= 1'b0;
         modify_flag    <= 1'b0;
         modify_address <= 32'h0;
         modify_data    <= 32'h0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (in_valid) begin
                  if (req_mem) begin
                     addr_q  <= in_sl_address;
                     data_q  <= in_sl_data;
                     n_q     <= len_to_n(in_sl_length);
                     sgn_q   <= in_sl_signed;
                     mf_q    <= in_modify_flag;
                     maddr_q <= in_modify_address;
                     mdata_q <= in_modify_data;
                     word_q  <= 32'h0;
                     idx     <= 3'd0;
                     state   <= in_load ? StLoad : StStore;
                  end else begin
                     out_valid      <= 1'b1;
                     modify_flag    <= in_modify_flag;
                     modify_address <= in_modify_address;
                     modify_data    <= in_modify_data;
                  end
               end
            end
            StLoad: begin
               word_q <= load_word;
               if (idx == n_q) begin
                  state          <= StIdle;
                  idx            <= 3'd0;
                  out_valid      <= 1'b1;
                  modify_flag    <= mf_q;
                  modify_address <= maddr_q;
                  modify_data    <= load_ext;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            StStore: begin
               if (idx == 3'(n_q - 3'd1)) begin
                  state          <= StIdle;
                  idx            <= 3'd0;
                  out_valid      <= 1'b1;
                  modify_flag    <= mf_q;
                  modify_address <= maddr_q;
                  modify_data    <= mdata_q;
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            default: begin
               state <= StIdle;
               idx   <= 3'd0;
            end
         endcase
      end
   end

endmodule
